wave_rom_server: RTL and testbench

// Responder side of the wave-sample DMA fetch interface. Multi-channel sample players raise
// per-channel read requests; this block arbitrates them round-robin onto the single read port
// of the wave ROM dpram and returns each byte with a one-cycle acknowledge.
// It sits between the sound channels and dpram port B. The ioctl loader owns port A.

---
 rtl/wave_rom_if.sv | 22 ++
 rtl/wave_rom_server.sv | 103 ++++++++++
 tb/tb_wave_rom_server.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/wave_rom_if.sv
// Channel-side fetch bus between the sample players and the wave ROM server.
interface wave_rom_if #(
    parameter int unsigned CHANS = 8,
    parameter int unsigned AW    = 17
);
    logic                  dl_busy;
    logic [CHANS-1:0]      req;
    logic [CHANS*AW-1:0]   req_addr;
    logic [CHANS-1:0]      ack;
    logic [7:0]            rsp_data;
    logic                  busy;

    modport master (
        output dl_busy, req, req_addr,
        input  ack, rsp_data, busy
    );

    modport slave (
        input  dl_busy, req, req_addr,
        output ack, rsp_data, busy
    );
endinterface

// File: rtl/wave_rom_server.sv
// Round-robin arbiter serving per-channel byte fetches from the wave ROM read port,
// returning each byte with a one-cycle per-channel acknowledge.
module wave_rom_server #(
    parameter int unsigned CHANS   = 8,
    parameter int unsigned AW      = 17,
    parameter int unsigned ROM_LAT = 1
) (
    input  logic          i_clk_sys,
    input  logic          i_reset,
    wave_rom_if.slave     bus,
    output logic [AW-1:0] o_rom_addr,
    input  logic [7:0]    i_rom_q
);
    localparam int unsigned PW = (CHANS > 1) ? $clog2(CHANS) : 1;

    logic [PW-1:0]    r_rr;
    logic [CHANS-1:0] r_outst;
    logic [CHANS-1:0] r_ack;
    logic [7:0]       r_rsp;
    logic [AW-1:0]    r_rom_addr;
    logic             r_busy;
    logic [ROM_LAT:0] r_pv;
    logic [PW-1:0]    r_pt [ROM_LAT+1];

    logic [CHANS-1:0] w_elig;
    logic [AW-1:0]    w_addr [CHANS];
    logic             w_gnt;
    logic [PW-1:0]    w_g;
    logic [PW-1:0]    w_cand;
    logic [PW-1:0]    w_rr_nxt;
    logic [AW-1:0]    w_gaddr;
    logic [CHANS-1:0] w_gnt_oh;
    logic [CHANS-1:0] w_done_oh;
    logic [CHANS-1:0] w_outst_nxt;

    // A channel acked this cycle stays masked until the following cycle.
    assign w_elig = bus.req & ~r_outst & ~r_ack & {CHANS{~bus.dl_busy}};

    always_comb begin : addr_unpack
        for (int unsigned i = 0; i < CHANS; i++) begin
            w_addr[i] = bus.req_addr[i*AW +: AW];
        end
    end

    // Search from the rr pointer, wrapping explicitly modulo CHANS.
    always_comb begin : arbiter
        w_gnt  = 1'b0;
        w_g    = '0;
        w_cand = '0;
        for (int unsigned k = 0; k < CHANS; k++) begin
            w_cand = PW'((32'(r_rr) + k) % CHANS);
            if (!w_gnt && w_elig[w_cand]) begin
                w_gnt = 1'b1;
                w_g   = w_cand;
            end
        end
    end

    always_comb begin : next_values
        w_rr_nxt    = (w_g == PW'(CHANS - 1)) ? '0 : w_g + 1'b1;
        w_gaddr     = w_addr[w_g];
        w_gnt_oh    = w_gnt ? (CHANS'(1) << w_g) : '0;
        w_done_oh   = r_pv[ROM_LAT] ? (CHANS'(1) << r_pt[ROM_LAT]) : '0;
        w_outst_nxt = (r_outst & ~w_done_oh) | w_gnt_oh;
    end

    always_ff @(posedge i_clk_sys) begin
        if (i_reset) begin
            r_rr       <= '0;
            r_outst    <= '0;
            r_ack      <= '0;
            r_rsp      <= '0;
            r_rom_addr <= '0;
            r_busy     <= 1'b0;
            r_pv       <= '0;
            for (int unsigned k = 0; k <= ROM_LAT; k++) begin
                r_pt[k] <= '0;
            end
        end else begin
            r_outst <= w_outst_nxt;
            r_busy  <= |w_outst_nxt;
            r_ack   <= w_done_oh;
            if (r_pv[ROM_LAT]) begin
                r_rsp <= i_rom_q;
            end
            if (w_gnt) begin
                r_rr       <= w_rr_nxt;
                r_rom_addr <= w_gaddr;
            end
            // Tag pipeline tracks the fetch from address issue to ROM data.
            r_pv    <= {r_pv[ROM_LAT-1:0], w_gnt};
            r_pt[0] <= w_g;
            for (int unsigned k = 1; k <= ROM_LAT; k++) begin
                r_pt[k] <= r_pt[k-1];
            end
        end
    end

    assign bus.ack      = r_ack;
    assign bus.rsp_data = r_rsp;
    assign bus.busy     = r_busy;
    assign o_rom_addr   = r_rom_addr;
endmodule

// File: tb/tb_wave_rom_server.sv
// Directed bench for wave_rom_server: single fetch, arbitration order, download blocking,
// reset during flight and back-to-back fetches on one channel.
module tb_wave_rom_server;
    localparam int unsigned CHANS = 8;
    localparam int unsigned AW    = 17;

    logic          clk;
    logic          rst;
    logic [AW-1:0] rom_addr;
    logic [7:0]    rom_q;

    int n_vec = 0;
    int n_err = 0;

    wave_rom_if #(.CHANS(CHANS), .AW(AW)) bus ();

    wave_rom_server #(.CHANS(CHANS), .AW(AW), .ROM_LAT(1)) dut (
        .i_clk_sys  (clk),
        .i_reset    (rst),
        .bus        (bus.slave),
        .o_rom_addr (rom_addr),
        .i_rom_q    (rom_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM contents: 0x123 holds 0xA5.
    function automatic logic [7:0] rom_byte(input logic [AW-1:0] a);
        return (a[7:0] ^ 8'h86) ^ {1'b0, a[16:10]};
    endfunction

    // Synchronous one-cycle-latency ROM port.
    always @(posedge clk) rom_q <= rom_byte(rom_addr);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_addr(input int ch, input logic [AW-1:0] a);
        bus.req_addr[ch*AW +: AW] = a;
    endtask

    task automatic do_reset();
        bus.req     = '0;
        bus.dl_busy = 1'b0;
        rst         = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    logic [AW-1:0] addr_tab [CHANS];
    logic [AW-1:0] a6;
    int            exp_ch;
    int            got_acks;
    int            last_ack;
    bit            quiet;

    initial begin
        bus.req_addr = '0;
        do_reset();
        check("rst_ack",  32'(bus.ack), 32'h0);
        check("rst_rsp",  32'(bus.rsp_data), 32'h0);
        check("rst_addr", 32'(rom_addr), 32'h0);
        check("rst_busy", 32'(bus.busy), 32'h0);

        // 1: single fetch on ch2
        set_addr(2, 17'h00123);
        bus.req[2] = 1'b1;
        tick();
        check("t1_addr", 32'(rom_addr), 32'h123);
        check("t1_busy1", 32'(bus.busy), 32'h1);
        check("t1_ack1", 32'(bus.ack), 32'h0);
        tick();
        check("t1_busy2", 32'(bus.busy), 32'h1);
        check("t1_ack2", 32'(bus.ack), 32'h0);
        tick();
        check("t1_ack3", 32'(bus.ack), 32'h04);
        check("t1_rsp", 32'(bus.rsp_data), 32'hA5);
        check("t1_busy3", 32'(bus.busy), 32'h0);
        bus.req[2] = 1'b0;
        tick();
        check("t1_ack_off", 32'(bus.ack), 32'h0);
        check("t1_rsp_hold", 32'(bus.rsp_data), 32'hA5);

        // 2: ch0 and ch5 together from rr=0, then ch1+ch7 shows the pointer moved to 6
        do_reset();
        set_addr(0, 17'h00010);
        set_addr(5, 17'h00020);
        bus.req[0] = 1'b1;
        bus.req[5] = 1'b1;
        tick();
        tick();
        tick();
        check("t2_ack_ch0", 32'(bus.ack), 32'h01);
        check("t2_rsp_ch0", 32'(bus.rsp_data), 32'(rom_byte(17'h00010)));
        bus.req[0] = 1'b0;
        tick();
        check("t2_ack_ch5", 32'(bus.ack), 32'h20);
        check("t2_rsp_ch5", 32'(bus.rsp_data), 32'(rom_byte(17'h00020)));
        bus.req[5] = 1'b0;
        set_addr(1, 17'h00031);
        set_addr(7, 17'h00077);
        bus.req[1] = 1'b1;
        bus.req[7] = 1'b1;
        tick();
        tick();
        tick();
        check("t2_rr_ch7", 32'(bus.ack), 32'h80);
        bus.req[7] = 1'b0;
        tick();
        check("t2_rr_ch1", 32'(bus.ack), 32'h02);
        bus.req[1] = 1'b0;

        // 3: fairness with all channels requesting continuously
        do_reset();
        for (int i = 0; i < int'(CHANS); i++) begin
            addr_tab[i] = AW'(17'h00400 * i + 17'h00011 * i + 17'h3);
            set_addr(i, addr_tab[i]);
        end
        bus.req  = '1;
        exp_ch   = 0;
        got_acks = 0;
        for (int c = 0; c < 200 && got_acks < 32; c++) begin
            tick();
            if (bus.ack != '0) begin
                check("t3_order", 32'(bus.ack), 32'(8'(1) << exp_ch));
                check("t3_data", 32'(bus.rsp_data), 32'(rom_byte(addr_tab[exp_ch])));
                exp_ch = (exp_ch + 1) % int'(CHANS);
                got_acks++;
            end
        end
        check("t3_count", 32'(got_acks), 32'd32);
        bus.req = '0;

        // 4: download blocks new grants but lets the in-flight fetch finish
        do_reset();
        set_addr(1, 17'h00040);
        bus.req[1] = 1'b1;
        tick();
        bus.dl_busy = 1'b1;
        set_addr(3, 17'h00300);
        bus.req[3] = 1'b1;
        tick();
        check("t4_ack_pre", 32'(bus.ack), 32'h0);
        tick();
        check("t4_inflight", 32'(bus.ack), 32'h02);
        bus.req[1] = 1'b0;
        quiet = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (bus.ack != '0) quiet = 1'b0;
        end
        check("t4_quiet", 32'(quiet), 32'h1);
        check("t4_idle_busy", 32'(bus.busy), 32'h0);
        bus.dl_busy = 1'b0;
        tick();
        check("t4_d1", 32'(bus.ack), 32'h0);
        tick();
        check("t4_d2", 32'(bus.ack), 32'h0);
        tick();
        check("t4_ack3", 32'(bus.ack), 32'h08);
        check("t4_rsp3", 32'(bus.rsp_data), 32'(rom_byte(17'h00300)));
        bus.req[3] = 1'b0;

        // 5: reset right after a grant discards the fetch
        do_reset();
        set_addr(1, 17'h00055);
        bus.req[1] = 1'b1;
        tick();
        rst = 1'b1;
        tick();
        check("t5_ack", 32'(bus.ack), 32'h0);
        check("t5_addr", 32'(rom_addr), 32'h0);
        check("t5_busy", 32'(bus.busy), 32'h0);
        rst = 1'b0;
        bus.req[1] = 1'b0;
        quiet = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (bus.ack != '0) quiet = 1'b0;
        end
        check("t5_no_ack", 32'(quiet), 32'h1);

        // 6: ch4 back-to-back, advancing the address on each ack
        do_reset();
        a6 = 17'h01000;
        set_addr(4, a6);
        bus.req[4] = 1'b1;
        got_acks = 0;
        last_ack = 0;
        for (int c = 1; c <= 60 && got_acks < 5; c++) begin
            tick();
            if (bus.ack != '0) begin
                check("t6_ack", 32'(bus.ack), 32'h10);
                check("t6_data", 32'(bus.rsp_data), 32'(rom_byte(a6)));
                check("t6_gap", 32'(c - last_ack), (got_acks == 0) ? 32'd3 : 32'd4);
                last_ack = c;
                got_acks++;
                a6 = a6 + 17'h1;
                set_addr(4, a6);
            end
        end
        check("t6_count", 32'(got_acks), 32'd5);
        bus.req[4] = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
